// File: rtl/module_buffer_reader_sd.sv
// module_buffer_reader_sd: streams the sample capture buffer out as MSB-first
// byte pairs over a valid/ready interface on a start request.
`default_nettype none

module module_buffer_reader_sd #(
  parameter int N_MUESTRAS = 512,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_buffer_i,
  output logic [ADDR_W-1:0] addr_buffer_o,
  output logic              re_buffer_o,
  output logic [7:0]        byte_o,
  output logic              byte_valid_o,
  input  logic              byte_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WAIT    = 3'd2,
    S_SEND_HI = 3'd3,
    S_SEND_LO = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_MUESTRAS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   sample_q, sample_d;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sample_q <= sample_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    sample_d     = sample_q;
    re_buffer_o  = 1'b0;
    byte_o       = 8'h00;
    byte_valid_o = 1'b0;
    done_o       = 1'b0;
    busy_o       = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        re_buffer_o = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // Buffer has one cycle of read latency; its data is valid only now.
        sample_d = data_buffer_i;
        state_d  = S_SEND_HI;
      end
      S_SEND_HI: begin
        byte_o       = sample_q[DATA_W-1 -: 8];
        byte_valid_o = 1'b1;
        if (byte_ready_i) state_d = S_SEND_LO;
      end
      S_SEND_LO: begin
        byte_o       = sample_q[7:0];
        byte_valid_o = 1'b1;
        if (byte_ready_i) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign addr_buffer_o = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_module_buffer_reader_sd.sv
// tb_module_buffer_reader_sd: randomized directed bench for the buffer reader,
// checked against a byte-stream model built straight from the buffer contents.
`default_nettype none

module tb_module_buffer_reader_sd;

  localparam int N = 512;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] data_buffer_i = 16'h0000;
  logic [8:0]  addr_buffer_o;
  logic        re_buffer_o;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        byte_ready_i = 1'b0;
  logic        busy_o;
  logic        done_o;

  module_buffer_reader_sd #(.N_MUESTRAS(N), .ADDR_W(9), .DATA_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .data_buffer_i(data_buffer_i), .addr_buffer_o(addr_buffer_o),
    .re_buffer_o(re_buffer_o), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
    .byte_ready_i(byte_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Capture buffer: synchronous read, one cycle latency.
  logic [15:0] mem [N];
  always @(posedge clk_i) if (re_buffer_o) data_buffer_i <= mem[addr_buffer_o];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Observations gathered over one transfer.
  logic [7:0] got[$];
  logic [7:0] exp_bytes[$];
  int re_cnt, done_cnt, done_cyc, busy_cnt, stab_bad, vbad, addr_bad;
  bit first_ok, aborted;
  logic idle_busy;

  function automatic void build_expected();
    exp_bytes.delete();
    for (int a = 0; a < N; a++) begin
      exp_bytes.push_back(mem[a][15:8]);
      exp_bytes.push_back(mem[a][7:0]);
    end
  endfunction

  // Entry: at a negedge with the DUT idle. Cycle 1 is the one after start_i is sampled.
  task automatic transfer(input bit rnd, input bit hold_start, input int restart_at, input int abort_at);
    logic [7:0] pb;
    bit pv, pr, pre;
    got.delete();
    re_cnt = 0; done_cnt = 0; done_cyc = 0; busy_cnt = 0;
    stab_bad = 0; vbad = 0; addr_bad = 0; first_ok = 0; aborted = 0; idle_busy = 1'bx;
    pv = 0; pr = 0; pre = 0; pb = 8'h00;
    start_i = 1'b1;
    for (int c = 1; c <= 20000; c++) begin
      @(negedge clk_i);
      if (!hold_start)
        start_i = (restart_at >= 0) && re_buffer_o && (int'(addr_buffer_o) == restart_at);
      if (abort_at >= 0 && byte_valid_o && got.size() == 2*abort_at + 1) begin
        rst_i = 1'b0;
        byte_ready_i = 1'b1;
        aborted = 1;
        break;
      end
      byte_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (c == 1) first_ok = re_buffer_o && (addr_buffer_o == 9'd0);
      if (busy_o) busy_cnt++;
      if (re_buffer_o) begin
        if (int'(addr_buffer_o) != re_cnt) addr_bad++;
        re_cnt++;
      end
      if (byte_valid_o && (re_buffer_o || pre || done_o || !busy_o)) vbad++;
      if (pv && !pr && (!byte_valid_o || byte_o != pb)) stab_bad++;
      if (byte_valid_o && byte_ready_i) got.push_back(byte_o);
      if (done_o) begin done_cnt++; done_cyc = c; end
      pv = byte_valid_o; pr = byte_ready_i; pb = byte_o; pre = re_buffer_o;
      if (done_cyc != 0 && c == done_cyc + 1) begin
        idle_busy = busy_o;
        break;
      end
    end
  endtask

  task automatic report(input string tag, input bit exact_timing);
    int bad = 0;
    int lim = (got.size() < exp_bytes.size()) ? got.size() : exp_bytes.size();
    for (int i = 0; i < lim; i++) if (got[i] !== exp_bytes[i]) bad++;
    chk({tag, "_byte_count"}, got.size(), exp_bytes.size());
    chk({tag, "_byte_mismatches"}, bad, 0);
    chk({tag, "_re_strobes"}, re_cnt, N);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_read_addr_order"}, addr_bad, 0);
    chk({tag, "_valid_outside_send"}, vbad, 0);
    chk({tag, "_hold_stability"}, stab_bad, 0);
    chk({tag, "_first_read_addr0"}, 32'(first_ok), 1);
    chk({tag, "_busy_low_after_done"}, 32'(idle_busy), 0);
    if (exact_timing) begin
      chk({tag, "_done_cycle"}, done_cyc, 4*N + 1);
      chk({tag, "_busy_cycles"}, busy_cnt, 4*N + 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(addr_buffer_o), 0);
    chk({tag, "_re"}, 32'(re_buffer_o), 0);
    chk({tag, "_byte"}, 32'(byte_o), 0);
    chk({tag, "_valid"}, 32'(byte_valid_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
  endtask

  initial begin
    int quiet_bad;
    for (int a = 0; a < N; a++) mem[a] = 16'(a * 3);
    build_expected();

    // Reset with ready high and start low.
    byte_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b1;

    // Idle with ready high: nothing offered.
    quiet_bad = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (byte_valid_o || busy_o || re_buffer_o || done_o) quiet_bad++;
    end
    chk("idle_ready_high_quiet", quiet_bad, 0);

    // 1: ready held high, word = address*3.
    chk("model_last_hi", 32'(exp_bytes[2*N-2]), 32'h05);
    transfer(1'b0, 1'b0, -1, -1);
    report("ready1", 1'b1);

    // 2: random back-pressure, same buffer contents.
    transfer(1'b1, 1'b0, -1, -1);
    report("rand_ready", 1'b0);

    // 3: random buffer, start re-pulsed at sample 100.
    for (int a = 0; a < N; a++) mem[a] = 16'($urandom);
    build_expected();
    transfer(1'b0, 1'b0, 100, -1);
    report("restart_ignored", 1'b1);

    // 4: reset during SEND_LO of sample 37.
    transfer(1'b1, 1'b0, -1, 37);
    chk("abort_reached", 32'(aborted), 1);
    start_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("abort");
    rst_i = 1'b1;
    quiet_bad = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (done_o || byte_valid_o || busy_o) quiet_bad++;
    end
    chk("abort_no_done", quiet_bad, 0);
    transfer(1'b1, 1'b0, -1, -1);
    report("after_abort", 1'b0);

    // 5: start held high -> two back-to-back transfers.
    for (int a = 0; a < N; a++) mem[a] = 16'($urandom);
    build_expected();
    transfer(1'b0, 1'b1, -1, -1);
    report("held_first", 1'b1);
    transfer(1'b0, 1'b1, -1, -1);
    start_i = 1'b0;
    report("held_second", 1'b1);

    @(negedge clk_i);
    chk("final_idle_busy", 32'(busy_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/module_buffer_reader_sd.md
Name: module_buffer_reader_sd

Overview:
- Read side of the 512-sample light-sensor capture buffer.
- On a start pulse from the control micro (the save command), fetches every sample from the buffer in address order.
- Serialises each sample into two bytes, MSB first, over a valid/ready byte stream to the SD/SPI write path.
- Reports busy while transferring and pulses done when the last byte is accepted.

Parameters:
- N_MUESTRAS, 512, number of samples in the buffer.
- ADDR_W, 9, buffer address width; must satisfy 2^ADDR_W >= N_MUESTRAS.
- DATA_W, 16, sample word width; fixed at 2 bytes.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-low reset.
- start_i  input  1  start request, level or pulse; sampled only in IDLE.
- data_buffer_i  input  16  buffer read data; valid one cycle after re_buffer_o.
- addr_buffer_o  output  ADDR_W  buffer read address.
- re_buffer_o  output  1  buffer read enable, one-cycle strobe per sample.
- byte_o  output  8  byte to SD/SPI path.
- byte_valid_o  output  1  byte_o holds a valid byte.
- byte_ready_i  input  1  sink accepts byte_o on an edge where byte_valid_o=1.
- busy_o  output  1  transfer in progress; every state except IDLE.
- done_o  output  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset: rst_i=0 at a rising edge forces IDLE and clears every output to 0 (addr_buffer_o=0, byte_o=0) and the internal sample register. This applies mid-transfer too: the transfer aborts, no further bytes are offered, and done_o is not pulsed.
- IDLE:
  - busy_o=0.
  - start_i=1 -> READ with addr_buffer_o=0.
  - start_i is ignored in all other states.
- READ (1 cycle):
  - re_buffer_o=1 with the current address -> WAIT.
- WAIT (1 cycle):
  - data_buffer_i is valid this cycle and is latched into a 16-bit sample register at the closing edge -> SEND_HI.
- SEND_HI:
  - byte_o=sample[15:8], byte_valid_o=1.
  - byte_valid_o=1 && byte_ready_i=1 at an edge -> SEND_LO.
  - Otherwise hold; byte_o and byte_valid_o stay stable.
- SEND_LO:
  - byte_o=sample[7:0], byte_valid_o=1; same hold rule.
  - On handshake with addr=N_MUESTRAS-1 -> DONE.
  - On handshake otherwise -> address+1, then READ.
- DONE (1 cycle):
  - done_o=1, busy_o=1, byte_valid_o=0.
  - addr_buffer_o returns to 0 -> IDLE.
- Address arithmetic:
  - Unsigned ADDR_W bits; increments only on the SEND_LO handshake.
  - Never exceeds N_MUESTRAS-1 and never wraps during a transfer.
- byte_valid_o is 0 in IDLE, READ, WAIT and DONE. byte_ready_i is ignored in those states.
- Timing with byte_ready_i held at 1:
  - Each sample costs 4 cycles (READ, WAIT, SEND_HI, SEND_LO).
  - Number cycles from 1 after the edge that samples start_i.
  - done_o is high in cycle 4*N_MUESTRAS+1 (2049 at default); busy_o is high in cycles 1..2049.
- Back-pressure: byte_ready_i=0 stretches SEND_HI or SEND_LO indefinitely with no data loss and no re-read of the buffer.
- start_i held high through DONE: a new transfer starts from address 0 on the edge after returning to IDLE.
- re_buffer_o is asserted exactly N_MUESTRAS times per completed transfer.

Test Plan:
- Reset, then a start pulse, buffer preloaded with word = address*3, ready held 1 -> 1024 bytes in order 00,00,00,03,00,06,…,05,FD; done_o a single pulse in cycle 2049; busy_o low at cycle 2050.
- Random byte_ready_i (50%) over the full transfer -> byte sequence identical to the previous scenario; byte_o stable whenever valid=1 and ready=0; exactly 512 re_buffer_o strobes.
- start_i pulsed again during a transfer (at sample 100) -> ignored; no restart, address continues, single done_o.
- rst_i driven 0 while in SEND_LO of sample 37 -> next cycle all outputs 0 and state IDLE; no done_o; a subsequent start transfers from address 0.
- start_i held high continuously -> two back-to-back full transfers, each ending in a done_o pulse, with one IDLE cycle between them.
- byte_ready_i=1 while idle, and ready toggling in READ/WAIT -> no handshake counted; byte_valid_o stays 0 outside SEND states.
